// File: rtl/grf_multiport.sv
// Multi-port general register file: two prioritised write ports,
// optional write->read bypass and a per-register pending-write scoreboard.
module grf_multiport #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              bset,
    input  logic [AW-1:0]     bset_a,
    output logic [31:0]       wr_cnt
);

    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [31:0]     r_cnt;

    logic w_c0;
    logic w_c1;
    logic w_set;

    // Address is backed by a real, writable register (not out of range, not r0).
    function automatic logic f_ok(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Port 1 is the younger instruction, so it alone commits on a collision.
    assign w_c1  = we1 && f_ok(wa1);
    assign w_c0  = we0 && f_ok(wa0) && !(w_c1 && (wa1 == wa0));
    assign w_set = bset && f_ok(bset_a);

    assign wr_cnt = r_cnt;

    // Commit writes, update the scoreboard and count committed writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_c1 && (wa1 == AW'(i))) begin
                    r_mem[i] <= wd1;
                end else if (w_c0 && (wa0 == AW'(i))) begin
                    r_mem[i] <= wd0;
                end
                // A new producer issued this cycle outranks the retiring one.
                if (w_set && (bset_a == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_c1 && (wa1 == AW'(i))) ||
                             (w_c0 && (wa0 == AW'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_cnt <= r_cnt + 32'(w_c0) + 32'(w_c1);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        logic          w_b;
        logic          w_hit;

        assign w_a   = ra[k*AW +: AW];
        assign w_hit = (w_c1 && (wa1 == w_a)) || (w_c0 && (wa0 == w_a));
        assign rd[k*DW +: DW] = w_d;
        assign rbusy[k]       = w_b;

        // Read mux with optional same-cycle forwarding of committing data.
        always_comb begin
            w_d = '0;
            w_b = 1'b0;
            if (f_ok(w_a)) begin
                for (int i = 0; i < NREG; i++) begin
                    if (w_a == AW'(i)) begin
                        w_d = r_mem[i];
                        w_b = r_busy[i];
                    end
                end
                if (BYPASS != 0) begin
                    if (w_c1 && (wa1 == w_a)) begin
                        w_d = wd1;
                    end else if (w_c0 && (wa0 == w_a)) begin
                        w_d = wd0;
                    end
                    if (w_hit && !(w_set && (bset_a == w_a))) begin
                        w_b = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: bypass, no-bypass and
// 4-read/16-register instances share the write/scoreboard stimulus.
module tb_grf_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, bset;
    logic [4:0]  wa0, wa1, bset_a;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra2;
    logic [19:0] ra4;

    logic [63:0]  rd_a, rd_b;
    logic [1:0]   rb_a, rb_b;
    logic [31:0]  cnt_a, cnt_b, cnt_c;
    logic [127:0] rd_c;
    logic [3:0]   rb_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grf_multiport u_byp (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra2), .rd(rd_a), .rbusy(rb_a),
        .bset(bset), .bset_a(bset_a), .wr_cnt(cnt_a)
    );

    grf_multiport #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra2), .rd(rd_b), .rbusy(rb_b),
        .bset(bset), .bset_a(bset_a), .wr_cnt(cnt_b)
    );

    grf_multiport #(.NRD(4), .NREG(16)) u_q (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra4), .rd(rd_c), .rbusy(rb_c),
        .bset(bset), .bset_a(bset_a), .wr_cnt(cnt_c)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        bs;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] enb;
        logic        eb0;
        logic        eb1;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; wa0 = 0; wd0 = 0;
        we1 = 0; wa1 = 0; wd1 = 0;
        bset = 0; bset_a = 0;
    endtask

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | bs ba | ra0 ra1 | e0 e1 enb | eb0 eb1 | cnt
        tv[0]  = '{1, 5, 32'h11, 1, 5, 32'h22, 0, 0, 5, 5,
                   32'h22, 32'h22, 32'h0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 3,
                   32'h22, 32'h0, 32'h22, 0, 0, 1};
        tv[2]  = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 5,
                   32'h0, 32'h22, 32'h0, 0, 0, 1};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5,
                   32'h0, 32'h22, 32'h0, 0, 0, 1};
        tv[4]  = '{1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 1, 2,
                   32'hA, 32'hB, 32'h0, 0, 0, 1};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2,
                   32'hA, 32'hB, 32'hA, 0, 0, 3};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 9,
                   32'h0, 32'h0, 32'h0, 0, 0, 3};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 9,
                   32'h0, 32'h0, 32'h0, 1, 1, 3};
        tv[8]  = '{0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 1,
                   32'h99, 32'hA, 32'h0, 1, 0, 3};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 1,
                   32'h99, 32'hA, 32'h99, 1, 0, 4};
        tv[10] = '{1, 9, 32'h77, 0, 0, 0, 0, 0, 9, 9,
                   32'h77, 32'h77, 32'h99, 0, 0, 4};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 9,
                   32'h77, 32'h77, 32'h77, 0, 0, 5};
        tv[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                   32'h0, 32'h0, 32'h0, 0, 0, 5};
        tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   32'h0, 32'h0, 32'h0, 0, 0, 5};
        tv[14] = '{1, 7, 32'hABCD, 0, 0, 0, 0, 0, 7, 9,
                   32'hABCD, 32'h77, 32'h0, 0, 0, 5};
        tv[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 9,
                   32'hABCD, 32'h77, 32'hABCD, 0, 0, 6};
        tv[16] = '{1, 4, 32'h44, 1, 0, 32'h55, 0, 0, 4, 0,
                   32'h44, 32'h0, 32'h0, 0, 0, 6};
        tv[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 0,
                   32'h44, 32'h0, 32'h44, 0, 0, 7};

        // Reset cycle swallows a concurrent write.
        idle();
        reset = 1'b1;
        ra2 = '0;
        ra4 = '0;
        repeat (2) @(posedge clk);
        #1;
        we0 = 1; wa0 = 3; wd0 = 32'hDEAD;
        bset = 1; bset_a = 3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        ra2 = {5'd3, 5'd3};
        #1;
        chk("rst_rd", rd_a[31:0], 32'h0);
        chk("rst_cnt", cnt_a, 32'h0);
        chk("rst_busy", 32'(rb_a), 32'h0);
        chk("rst_nob_rd", rd_b[31:0], 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
            we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
            bset = tv[i].bs; bset_a = tv[i].ba;
            ra2 = {tv[i].ra1, tv[i].ra0};
            #1;
            chk($sformatf("v%0d_rd0", i), rd_a[31:0], tv[i].e0);
            chk($sformatf("v%0d_rd1", i), rd_a[63:32], tv[i].e1);
            chk($sformatf("v%0d_rb0", i), 32'(rb_a[0]), 32'(tv[i].eb0));
            chk($sformatf("v%0d_rb1", i), 32'(rb_a[1]), 32'(tv[i].eb1));
            chk($sformatf("v%0d_cnt", i), cnt_a, tv[i].ecnt);
            chk($sformatf("v%0d_nob_rd0", i), rd_b[31:0], tv[i].enb);
            chk($sformatf("v%0d_nob_cnt", i), cnt_b, tv[i].ecnt);
            @(posedge clk);
            #1;
        end

        // Four read ports over a 16-entry file; 16 is out of range.
        idle();
        ra4 = {5'd0, 5'd16, 5'd2, 5'd1};
        #1;
        chk("q_rd0", rd_c[31:0], 32'hA);
        chk("q_rd1", rd_c[63:32], 32'hB);
        chk("q_rd2", rd_c[95:64], 32'h0);
        chk("q_rd3", rd_c[127:96], 32'h0);
        chk("q_cnt", cnt_c, 32'd7);

        // Write to reg 20: real in the 32-entry file, dropped in the 16-entry one.
        we0 = 1; wa0 = 20; wd0 = 32'h1234;
        ra4 = {5'd0, 5'd20, 5'd2, 5'd1};
        #1;
        chk("q_oob_rd", rd_c[95:64], 32'h0);
        @(posedge clk);
        #1;
        idle();
        ra2 = {5'd5, 5'd20};
        #1;
        chk("q_oob_cnt", cnt_c, 32'd7);
        chk("byp_r20_cnt", cnt_a, 32'd8);
        chk("byp_r20_rd", rd_a[31:0], 32'h1234);
        chk("q_oob_rd_after", rd_c[95:64], 32'h0);

        // Mid-run reset clears contents, busy and counters.
        bset = 1; bset_a = 5;
        @(posedge clk);
        #1;
        idle();
        ra2 = {5'd5, 5'd5};
        #1;
        chk("pre_rst_busy", 32'(rb_a), 32'h3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst2_rd", rd_a[31:0], 32'h0);
        chk("rst2_busy", 32'(rb_a), 32'h0);
        chk("rst2_cnt", cnt_a, 32'h0);
        chk("rst2_q_cnt", cnt_c, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
